// File: rtl/cl_ocl_reg_pkg.sv
// Shared definitions for the OCL AXI-Lite register slave: register map, response codes, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package cl_ocl_reg_pkg;

    localparam logic [31:0] HELLO_WORLD_REG_ADDR = 32'h0000_0500;
    localparam logic [31:0] VLED_REG_ADDR        = 32'h0000_0504;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_STROBE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    function automatic logic addr_mapped(input logic [31:0] addr);
        return (addr == HELLO_WORLD_REG_ADDR) || (addr == VLED_REG_ADDR);
    endfunction

endpackage

// File: rtl/cl_ocl_reg_slv.sv
// AXI-Lite slave bridging OCL to the register core; CL_OCL_SLV_ERR_RESP_EN enables SLVERR for unmapped addresses.
// Latency: AW then W, core strobe 1 cycle after W, bvalid the cycle after; read data registered on AR accept.
// Backpressure: one transaction in flight per direction; AW/AR not accepted while a response waits for bready/rready.
module cl_ocl_reg_slv
    import cl_ocl_reg_pkg::*;
#(
    parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_sync,

    input  logic        sh_ocl_awvalid,
    input  logic [31:0] sh_ocl_awaddr,
    output logic        ocl_sh_awready,
    input  logic        sh_ocl_wvalid,
    input  logic [31:0] sh_ocl_wdata,
    input  logic [3:0]  sh_ocl_wstrb,
    output logic        ocl_sh_wready,
    output logic        ocl_sh_bvalid,
    output logic [1:0]  ocl_sh_bresp,
    input  logic        sh_ocl_bready,

    input  logic        sh_ocl_arvalid,
    input  logic [31:0] sh_ocl_araddr,
    output logic        ocl_sh_arready,
    output logic        ocl_sh_rvalid,
    output logic [31:0] ocl_sh_rdata,
    output logic [1:0]  ocl_sh_rresp,
    input  logic        sh_ocl_rready,

    output logic [31:0] wr_addr,
    output logic [31:0] wdata,
    output logic        wready,
    input  logic [31:0] hello_world_q_byte_swapped,
    input  logic [15:0] vled_q
);

    wr_state_t   wr_state, wr_state_nxt;
    rd_state_t   rd_state, rd_state_nxt;
    logic        wr_err;
    logic        wr_err_nxt;
    logic [1:0]  rd_resp_nxt;
    logic [31:0] rd_mux;

    // Byte lanes are not honoured: every write is a full-word write.
    logic unused_wstrb;
    assign unused_wstrb = ^sh_ocl_wstrb;

`ifdef CL_OCL_SLV_ERR_RESP_EN
    assign wr_err_nxt  = !addr_mapped(sh_ocl_awaddr);
    assign rd_resp_nxt = addr_mapped(sh_ocl_araddr) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_err_nxt  = 1'b0;
    assign rd_resp_nxt = RESP_OKAY;
`endif

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // Ready/valid outputs are gated by reset so nothing handshakes while it is held.
    always_comb begin
        wr_state_nxt   = wr_state;
        ocl_sh_awready = 1'b0;
        ocl_sh_wready  = 1'b0;
        wready         = 1'b0;
        ocl_sh_bvalid  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                ocl_sh_awready = !rst_main_sync;
                if (sh_ocl_awvalid) wr_state_nxt = WR_DATA;
            end
            WR_DATA: begin
                ocl_sh_wready = !rst_main_sync;
                if (sh_ocl_wvalid) wr_state_nxt = WR_STROBE;
            end
            WR_STROBE: begin
                wready       = !rst_main_sync && !wr_err;
                wr_state_nxt = WR_RESP;
            end
            WR_RESP: begin
                ocl_sh_bvalid = !rst_main_sync;
                if (sh_ocl_bready) wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    assign ocl_sh_bresp = (ocl_sh_bvalid && wr_err) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        rd_state_nxt   = rd_state;
        ocl_sh_arready = 1'b0;
        ocl_sh_rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                ocl_sh_arready = !rst_main_sync;
                if (sh_ocl_arvalid) rd_state_nxt = RD_RESP;
            end
            RD_RESP: begin
                ocl_sh_rvalid = !rst_main_sync;
                if (sh_ocl_rready) rd_state_nxt = RD_IDLE;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = UNMAPPED_RDATA;
        case (sh_ocl_araddr)
            HELLO_WORLD_REG_ADDR: rd_mux = hello_world_q_byte_swapped;
            VLED_REG_ADDR:        rd_mux = {16'h0000, vled_q};
            default:              rd_mux = UNMAPPED_RDATA;
        endcase
    end

    // Read data is sampled on the AR edge, so a read racing the core strobe sees the old value.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            wr_addr      <= 32'h0;
            wdata        <= 32'h0;
            wr_err       <= 1'b0;
            ocl_sh_rdata <= 32'h0;
            ocl_sh_rresp <= RESP_OKAY;
        end else begin
            if (wr_state == WR_IDLE && sh_ocl_awvalid) begin
                wr_addr <= sh_ocl_awaddr;
                wr_err  <= wr_err_nxt;
            end
            if (wr_state == WR_DATA && sh_ocl_wvalid) begin
                wdata <= sh_ocl_wdata;
            end
            if (rd_state == RD_IDLE && sh_ocl_arvalid) begin
                ocl_sh_rdata <= rd_mux;
                ocl_sh_rresp <= rd_resp_nxt;
            end
        end
    end

endmodule

// File: doc/cl_ocl_reg_slv.md
CL_OCL_REG_SLV -- requirements
Module: cl_ocl_reg_slv

Interface
REQ-001 Parameter: UNMAPPED_RDATA, 32'hDEAD_BEEF, read data returned for unmapped addresses.
REQ-002 clk_main_a0  in  1  sole clock; all logic on its rising edge.
REQ-003 rst_main_sync  in  1  synchronous, active-high reset.
REQ-004 sh_ocl_awvalid / sh_ocl_awaddr  in  1/32  AXI-Lite write address.
REQ-005 ocl_sh_awready  out  1  write address accept.
REQ-006 sh_ocl_wvalid / sh_ocl_wdata / sh_ocl_wstrb  in  1/32/4  AXI-Lite write data (wstrb ignored; full-word writes).
REQ-007 ocl_sh_wready  out  1  write data accept.
REQ-008 ocl_sh_bvalid / ocl_sh_bresp  out  1/2  write response; sh_ocl_bready in 1.
REQ-009 sh_ocl_arvalid / sh_ocl_araddr  in  1/32; ocl_sh_arready out 1  read address channel.
REQ-010 ocl_sh_rvalid / ocl_sh_rdata / ocl_sh_rresp  out  1/32/2; sh_ocl_rready in 1  read data channel.
REQ-011 wr_addr / wdata  out  32/32  captured write address/data to register core.
REQ-012 wready  out  1  one-cycle write strobe to register core.
REQ-013 hello_world_q_byte_swapped  in  32; vled_q in 16  read-back sources from register core.

Function
REQ-014 Write FSM states: WR_IDLE, WR_DATA, WR_STROBE, WR_RESP; read FSM states: RD_IDLE, RD_RESP; the two FSMs run independently.
REQ-015 WR_IDLE: ocl_sh_awready=1; on awvalid, capture awaddr into wr_addr, go WR_DATA (awaddr ignored otherwise).
REQ-016 WR_DATA: ocl_sh_wready=1, awready=0; on wvalid, capture wdata, go WR_STROBE; W arriving before AW waits in WR_IDLE (wready=0).
REQ-017 WR_STROBE: wready=1 for exactly one cycle, then WR_RESP; AW handshake cycle N, W handshake earliest N+1, strobe N+2, bvalid N+3.
REQ-018 WR_RESP: bvalid=1 held with stable bresp until bready; transition to WR_IDLE on bvalid&bready; bready asserted early has no effect.
REQ-019 wr_addr/wdata hold last captured values between writes.
REQ-020 RD_IDLE: arready=1; on arvalid, register rdata in same edge and go RD_RESP.
REQ-021 Read decode: 32'h500 -> hello_world_q_byte_swapped; 32'h504 -> {16'h0, vled_q}; other -> UNMAPPED_RDATA.
REQ-022 RD_RESP: rvalid=1, rdata/rresp stable until rready; return to RD_IDLE on rvalid&rready.
REQ-023 Read of 32'h500 handshaken in the strobe cycle returns the pre-write value.
REQ-024 rresp/bresp = 2'b00 for mapped addresses.

Reset
REQ-025 rst_main_sync=1 forces WR_IDLE/RD_IDLE; wr_addr, wdata, ocl_sh_rdata = 0; wready, bvalid, rvalid, awready, wready(AXI), arready = 0 during reset; bresp/rresp = 0.
REQ-026 Reset mid-transaction abandons it with no wready strobe and no response; awready/arready return to 1 the cycle after reset deasserts.

Configuration
REQ-027 CL_OCL_SLV_ERR_RESP_EN defined: unmapped write -> no wready strobe, bresp=2'b10; unmapped read -> rresp=2'b10, rdata=UNMAPPED_RDATA.
REQ-028 CL_OCL_SLV_ERR_RESP_EN undefined: unmapped writes still strobe wready (core ignores them), all responses 2'b00.

Structure
REQ-029 Package cl_ocl_reg_pkg holds HELLO_WORLD_REG_ADDR (32'h500), VLED_REG_ADDR (32'h504), RESP_OKAY/RESP_SLVERR, and the write/read FSM state enums.
REQ-030 No sub-module; both FSMs and the read mux live in cl_ocl_reg_slv.

Verification
REQ-031 AW 32'h500 cycle 0, W 32'hDEAD_BEEF cycle 1 -> wready pulse cycle 2 with wr_addr=32'h500, wdata=32'hDEAD_BEEF; bvalid cycle 3, bresp=0.
REQ-032 W presented 3 cycles before AW -> ocl_sh_wready low until after AW accepted; exactly one strobe.
REQ-033 Read 32'h500 with hello_world_q_byte_swapped=32'hEFBE_ADDE -> rdata 32'hEFBE_ADDE; read 32'h504 with vled_q=16'hBEEF -> 32'h0000_BEEF.
REQ-034 bready/rready held low 10 cycles -> bvalid/rvalid and data stable, no new AW/AR accepted.
REQ-035 Read 32'h600: macro on -> rresp 2'b10, rdata 32'hDEAD_BEEF; macro off -> rresp 2'b00.
REQ-036 Assert reset in WR_DATA -> no wready strobe, no bvalid; awready=1 cycle after deassert.
